// File: rtl/issue_controller.sv
// Instruction queue and in-order issue scheduler between the Fetcher and the Decoder.
// Fetched instructions are buffered in a circular FIFO. At most one head entry is
// issued per cycle, and only when the ROB and the destination unit (LSB for
// LOAD/STORE, RS otherwise) can accept it. Issue outputs are registered.
module issue_controller #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear_in,
    input  logic        fet_valid_in,
    input  logic [31:0] fet_inst_in,
    input  logic [31:0] fet_pc_in,
    input  logic [31:0] fet_predict_pc_in,
    output logic        fet_full_out,
    input  logic        rob_full_in,
    input  logic        rs_full_in,
    input  logic        lsb_full_in,
    output logic        dec_issue_out,
    output logic [31:0] dec_inst_out,
    output logic [31:0] dec_pc_out,
    output logic [31:0] dec_predict_pc_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] pred_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic [ADDR_WIDTH:0]   count;

    logic       push;
    logic       pop;
    logic       head_is_mem;
    logic [6:0] head_opcode;

    assign fet_full_out = (count == FULL_COUNT);

    // Push/pop qualification before flush/freeze gating; head class selects LSB or RS
    always_comb begin
        head_opcode = inst_mem[head][6:0];
        head_is_mem = (head_opcode == OP_LOAD) || (head_opcode == OP_STORE);
        push        = fet_valid_in && !fet_full_out;
        pop         = (count != '0) && !rob_full_in &&
                      (head_is_mem ? !lsb_full_in : !rs_full_in);
    end

    // Queue storage: written at tail on an accepted push in a normal cycle
    always_ff @(posedge clk_in) begin
        if (!rst_in && !rob_clear_in && rdy_in && push) begin
            inst_mem[tail] <= fet_inst_in;
            pc_mem[tail]   <= fet_pc_in;
            pred_mem[tail] <= fet_predict_pc_in;
        end
    end

    // Pointers, occupancy and registered issue outputs; reset > flush > freeze > normal
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            dec_issue_out      <= 1'b0;
            dec_inst_out       <= '0;
            dec_pc_out         <= '0;
            dec_predict_pc_out <= '0;
        end else if (rob_clear_in) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            dec_issue_out <= 1'b0;
        end else if (!rdy_in) begin
            dec_issue_out <= 1'b0;
        end else begin
            dec_issue_out <= pop;
            if (push) begin
                tail <= tail + ADDR_WIDTH'(1);
            end
            if (pop) begin
                head               <= head + ADDR_WIDTH'(1);
                dec_inst_out       <= inst_mem[head];
                dec_pc_out         <= pc_mem[head];
                dec_predict_pc_out <= pred_mem[head];
            end
            case ({push, pop})
                2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_controller.sv
// Bench for issue_controller: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_issue_controller;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear_in;
    logic        fet_valid_in;
    logic [31:0] fet_inst_in;
    logic [31:0] fet_pc_in;
    logic [31:0] fet_predict_pc_in;
    logic        fet_full_out;
    logic        rob_full_in;
    logic        rs_full_in;
    logic        lsb_full_in;
    logic        dec_issue_out;
    logic [31:0] dec_inst_out;
    logic [31:0] dec_pc_out;
    logic [31:0] dec_predict_pc_out;

    int compared   = 0;
    int mismatched = 0;
    bit started    = 1'b0;

    issue_controller #(.ADDR_WIDTH(4)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .rob_clear_in       (rob_clear_in),
        .fet_valid_in       (fet_valid_in),
        .fet_inst_in        (fet_inst_in),
        .fet_pc_in          (fet_pc_in),
        .fet_predict_pc_in  (fet_predict_pc_in),
        .fet_full_out       (fet_full_out),
        .rob_full_in        (rob_full_in),
        .rs_full_in         (rs_full_in),
        .lsb_full_in        (lsb_full_in),
        .dec_issue_out      (dec_issue_out),
        .dec_inst_out       (dec_inst_out),
        .dec_pc_out         (dec_pc_out),
        .dec_predict_pc_out (dec_predict_pc_out)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
    } entry_t;

    entry_t      mq[$];
    logic        m_issue = 1'b0;
    logic [31:0] m_inst  = '0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_pred  = '0;

    function automatic bit goes_to_lsb(logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        return (op == 7'h03) || (op == 7'h23);
    endfunction

    always @(posedge clk_in) begin
        entry_t e;
        bit was_full;
        bit can;
        if (rst_in) begin
            mq.delete();
            m_issue = 1'b0;
            m_inst  = '0;
            m_pc    = '0;
            m_pred  = '0;
        end else if (rob_clear_in) begin
            mq.delete();
            m_issue = 1'b0;
        end else if (!rdy_in) begin
            m_issue = 1'b0;
        end else begin
            was_full = (mq.size() == 16);
            can = (mq.size() != 0) && !rob_full_in &&
                  (goes_to_lsb(mq[0].inst) ? !lsb_full_in : !rs_full_in);
            if (can) begin
                e = mq.pop_front();
                m_issue = 1'b1;
                m_inst  = e.inst;
                m_pc    = e.pc;
                m_pred  = e.pred;
            end else begin
                m_issue = 1'b0;
            end
            if (fet_valid_in && !was_full) begin
                e.inst = fet_inst_in;
                e.pc   = fet_pc_in;
                e.pred = fet_predict_pc_in;
                mq.push_back(e);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk_in) begin
        if (started) begin
            check("model_full",  32'(fet_full_out), 32'(mq.size() == 16));
            check("model_issue", 32'(dec_issue_out), 32'(m_issue));
            check("model_inst",  dec_inst_out, m_inst);
            check("model_pc",    dec_pc_out, m_pc);
            check("model_pred",  dec_predict_pc_out, m_pred);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        fet_valid_in      = 1'b1;
        fet_inst_in       = inst;
        fet_pc_in         = pc;
        fet_predict_pc_in = pc + 32'd4;
        tick();
        fet_valid_in      = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] w;
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear_in = 1'b0; fet_valid_in = 1'b0;
        fet_inst_in = '0; fet_pc_in = '0; fet_predict_pc_in = '0;
        rob_full_in = 1'b0; rs_full_in = 1'b0; lsb_full_in = 1'b0;
        tick(); tick();
        rst_in = 1'b0;
        started = 1'b1;
        check("rst_issue", 32'(dec_issue_out), 32'h0);
        check("rst_full",  32'(fet_full_out), 32'h0);

        // Stream: ADDI issues exactly two cycles after its push
        push(32'h00100093, 32'h0);
        check("stream_n1_issue", 32'(dec_issue_out), 32'h0);
        tick();
        check("stream_issue", 32'(dec_issue_out), 32'h1);
        check("stream_inst",  dec_inst_out, 32'h00100093);
        check("stream_pc",    dec_pc_out, 32'h0);
        check("stream_pred",  dec_predict_pc_out, 32'h4);
        tick();
        check("stream_one_shot", 32'(dec_issue_out), 32'h0);

        // Class stall: LW blocked by LSB, then ADD blocked by RS
        lsb_full_in = 1'b1;
        push(32'h0000a103, 32'h100);
        repeat (3) begin
            tick();
            check("lw_stall", 32'(dec_issue_out), 32'h0);
        end
        lsb_full_in = 1'b0;
        tick();
        check("lw_issue", 32'(dec_issue_out), 32'h1);
        check("lw_inst",  dec_inst_out, 32'h0000a103);
        rs_full_in = 1'b1;
        push(32'h002081b3, 32'h104);
        repeat (3) begin
            tick();
            check("add_stall", 32'(dec_issue_out), 32'h0);
        end
        rs_full_in = 1'b0;
        tick();
        check("add_issue", 32'(dec_issue_out), 32'h1);
        check("add_inst",  dec_inst_out, 32'h002081b3);
        tick();

        // Full and pointer wrap, three rounds
        for (int r = 0; r < 3; r++) begin
            rob_full_in = 1'b1;
            for (int i = 0; i < 16; i++) begin
                w = 32'h00000093 | (32'(i) << 20);
                push(w, 32'(i) * 32'd4);
            end
            check("full_flag", 32'(fet_full_out), 32'h1);
            push(32'hdeadbe93, 32'h40);
            check("full_hold", 32'(fet_full_out), 32'h1);
            // Release with a simultaneous push while full: must be dropped
            rob_full_in = 1'b0;
            push(32'hcafe0093, 32'h44);
            for (int i = 0; i < 16; i++) begin
                check("wrap_issue", 32'(dec_issue_out), 32'h1);
                check("wrap_pc",    dec_pc_out, 32'(i) * 32'd4);
                if (i != 15) tick();
            end
            check("wrap_not_full", 32'(fet_full_out), 32'h0);
            tick();
            check("wrap_drained", 32'(dec_issue_out), 32'h0);
        end

        // Flush with a push in the same cycle
        rob_full_in = 1'b1;
        for (int i = 0; i < 6; i++) push(32'h00000013, 32'h200 + 32'(i) * 32'd4);
        rob_clear_in = 1'b1;
        push(32'h00000013, 32'h218);
        rob_clear_in = 1'b0;
        rob_full_in = 1'b0;
        repeat (4) begin
            tick();
            check("flush_no_issue", 32'(dec_issue_out), 32'h0);
        end
        push(32'h00500293, 32'h300);
        tick();
        check("post_flush_issue", 32'(dec_issue_out), 32'h1);
        check("post_flush_pc",    dec_pc_out, 32'h300);
        tick();

        // Freeze for three cycles with four queued
        rob_full_in = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h00000013, 32'h400 + 32'(i) * 32'd4);
        rdy_in = 1'b0;
        rob_full_in = 1'b0;
        repeat (3) begin
            tick();
            check("freeze_no_issue", 32'(dec_issue_out), 32'h0);
        end
        rdy_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("thaw_issue", 32'(dec_issue_out), 32'h1);
            check("thaw_pc",    dec_pc_out, 32'h400 + 32'(i) * 32'd4);
        end
        tick();
        check("thaw_drained", 32'(dec_issue_out), 32'h0);

        // Reset mid-stream with five queued
        rob_full_in = 1'b1;
        for (int i = 0; i < 5; i++) push(32'h00000013, 32'h500 + 32'(i) * 32'd4);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("rst2_issue", 32'(dec_issue_out), 32'h0);
        check("rst2_inst",  dec_inst_out, 32'h0);
        check("rst2_pc",    dec_pc_out, 32'h0);
        check("rst2_pred",  dec_predict_pc_out, 32'h0);
        check("rst2_full",  32'(fet_full_out), 32'h0);
        rob_full_in = 1'b0;
        repeat (3) begin
            tick();
            check("rst2_empty", 32'(dec_issue_out), 32'h0);
        end

        started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
